// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit four-register CPU: sequencer state encoding,
// default HALT opcode and the register-field positions used by the datapath.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_ERROR     = 3'd6
  } state_e;

  localparam logic [7:0] HALT_OPCODE_DEF = 8'h70;

  localparam int RD_MSB = 3;
  localparam int RD_LSB = 2;
  localparam int RS_MSB = 1;
  localparam int RS_LSB = 0;

  function automatic logic [1:0] instr_rd(input logic [7:0] ins);
    return ins[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [1:0] instr_rs(input logic [7:0] ins);
    return ins[RS_MSB:RS_LSB];
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer: 4 cycles per instruction with zero-wait memory,
// fetch stalls on mem_ack, HALT and fetch-timeout are sticky until reset.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0]  HALT_OPCODE   = HALT_OPCODE_DEF,
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic               mem_ack,
  input  logic [7:0]         instr,
  output logic               mem_req,
  output logic               pc_en,
  output logic               ir_load,
  output logic               dec_en,
  output logic               exe_en,
  output logic               wb_en,
  output logic               halted,
  output logic               error,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int TO_W = (FETCH_TIMEOUT < 1) ? 1 : $clog2(FETCH_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [7:0]         opcode_q, opcode_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [COUNT_W-1:0] instr_count_q, instr_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      opcode_q      <= '0;
      to_cnt_q      <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      to_cnt_q      <= to_cnt_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    to_cnt_d      = '0;
    instr_count_d = instr_count_q;
    mem_req       = 1'b0;
    pc_en         = 1'b0;
    ir_load       = 1'b0;
    dec_en        = 1'b0;
    exe_en        = 1'b0;
    wb_en         = 1'b0;
    halted        = 1'b0;
    error         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run || step) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load  = 1'b1;
          pc_en    = 1'b1;
          opcode_d = instr;
          state_d  = ST_DECODE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          // A zero timeout lets the counter wrap harmlessly; it is never compared.
          if (FETCH_TIMEOUT != 0 && to_cnt_d == TO_W'(FETCH_TIMEOUT)) begin
            to_cnt_d = '0;
            state_d  = ST_ERROR;
          end
        end
      end
      ST_DECODE: begin
        dec_en = 1'b1;
        if (opcode_q == HALT_OPCODE) begin
          instr_count_d = instr_count_q + COUNT_W'(1);
          state_d       = ST_HALT;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        exe_en  = 1'b1;
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        wb_en         = 1'b1;
        instr_count_d = instr_count_q + COUNT_W'(1);
        state_d       = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      ST_ERROR: begin
        error = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multicycle control sequencer for the 8-bit four-register CPU datapath (PC, instruction register, A-D register file, operand latches, adder, result register).
- Generates the one-hot per-phase enables that step the datapath through FETCH/DECODE/EXECUTE/WRITEBACK.
- Handles a req/ack handshake to instruction memory, run/single-step control, the HALT opcode, fetch timeout and a retired-instruction counter.
- Sits between the debug/run control and the datapath; owns no datapath registers.

Parameters:
HALT_OPCODE, 8'h70, instruction byte that stops the processor
FETCH_TIMEOUT, 16, cycles spent in FETCH without mem_ack before entering ERROR; 0 disables the timeout
COUNT_W, 16, width of instr_count

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
run  in  1  level; while high, instructions execute back-to-back
step  in  1  one-cycle pulse; executes exactly one instruction when idle and run=0
mem_ack  in  1  instruction memory data valid this cycle
instr  in  8  instruction byte, sampled only when mem_ack=1 in FETCH
mem_req  out  1  instruction fetch request
pc_en  out  1  datapath PC <= PC+1
ir_load  out  1  datapath instruction register <= instr
dec_en  out  1  latch Rrd/Rrs operands
exe_en  out  1  latch adder result
wb_en  out  1  write result to register rd
halted  out  1  HALT opcode decoded; sticky
error  out  1  fetch timeout; sticky
state  out  3  current state encoding
instr_count  out  COUNT_W  retired instructions, including HALT

Behaviour:
- Reset (async): state=IDLE, all enables 0, mem_req=0, halted=0, error=0, instr_count=0, timeout counter=0. Outputs go low without waiting for a clock edge.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5, ERROR=6. Value 7 is illegal and returns to IDLE.
- IDLE: all enables 0. If run=1 or step=1, go to FETCH; both together count as one entry.
- FETCH:
  - mem_req=1 in every FETCH cycle.
  - On a cycle with mem_ack=1: ir_load=1 and pc_en=1 combinationally in that same cycle only. instr is captured into an internal opcode register. Next state is DECODE.
  - If mem_ack=0: the timeout counter increments. When it reaches FETCH_TIMEOUT (and FETCH_TIMEOUT≠0), go to ERROR. Counter clears on leaving FETCH.
- DECODE: dec_en=1 for exactly one cycle.
  - If captured opcode == HALT_OPCODE: go to HALT and increment instr_count.
  - Otherwise go to EXECUTE.
- EXECUTE: exe_en=1 for one cycle, then WRITEBACK.
- WRITEBACK: wb_en=1 for one cycle and instr_count increments (wraps modulo 2^COUNT_W). Next state is FETCH if run=1, else IDLE.
- HALT: halted=1. No further mem_req. Exits only on rst; run and step are ignored.
- ERROR: error=1, mem_req=0. Exits only on rst.
- Latency with zero-wait memory: 4 cycles per instruction in run mode; pc_en pulses every 4th cycle.
- Boundary conditions:
  - Dropping run mid-instruction lets that instruction complete, then the block enters IDLE.
  - step pulses outside IDLE are ignored; they are not queued.
  - mem_ack outside FETCH is ignored.
  - rst asserted in any state aborts immediately. A partially executed instruction is not retired and wb_en never asserts for it.
- Enables (dec_en, exe_en, wb_en) are Moore decodes of state and are mutually exclusive. ir_load and pc_en are Mealy on mem_ack.

Decomposition:
- Shared package cpu_pkg holds: state encoding localparams, HALT_OPCODE default, field positions rd=[3:2] and rs=[1:0] for use by the datapath.
- Single module, no sub-module. The timeout counter and instr_count are in-line registers.

Test Plan:
- Reset: rst=1 while run=1, ack=1 -> state=0, every output 0. Release rst -> FETCH on the next edge.
- Program run: ack tied high, stream 01,00,04,00,70 with run=1 -> pc_en pulses at 4-cycle spacing. DECODE of 70 -> HALT, halted=1, instr_count=5, mem_req stays 0 for 20 further cycles.
- Wait states: ack delayed 3 cycles -> mem_req high for 4 cycles; single ir_load/pc_en pulse on the ack cycle only.
- Single step: run=0, one step pulse with instr=04 -> one each of dec_en, exe_en, wb_en, then IDLE with instr_count=1. A second step pulse during EXECUTE produces no extra instruction.
- Timeout: run=1, ack never asserted -> after 16 FETCH cycles state=6, error=1, mem_req=0. run toggling has no effect until rst.
- Async reset mid-op: assert rst between edges during EXECUTE -> exe_en, state and mem_req go to 0 before the next posedge; wb_en never pulses and instr_count is unchanged.
